// File: rtl/ifetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller and its prefetch queue.
package ifetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam int IFQ_DEPTH = 2;
  localparam int IFQ_W     = 64;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Two-entry prefetch FIFO of {pc, instr}; flush wins over enq/deq and the head
// register keeps the last dequeued entry once the queue drains.
module ifetch_queue
  import ifetch_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enq,
  input  logic             deq,
  input  logic             flush,
  input  logic [IFQ_W-1:0] din,
  output logic [IFQ_W-1:0] dout,
  output logic [1:0]       count
);

  logic [IFQ_W-1:0] head_q;
  logic [IFQ_W-1:0] tail_q;
  logic             do_deq;
  logic             do_enq;

  assign do_deq = deq && (count != 2'd0);
  assign do_enq = enq && ((count < 2'(IFQ_DEPTH)) || do_deq);
  assign dout   = head_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      count  <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (do_enq) begin
            head_q <= din;
            count  <= 2'd1;
          end
        end
        2'd1: begin
          if (do_enq && do_deq) begin
            head_q <= din;
          end else if (do_enq) begin
            tail_q <= din;
            count  <= 2'd2;
          end else if (do_deq) begin
            count <= 2'd0;
          end
        end
        default: begin
          // Full: a dequeue shifts the tail forward, optionally refilling it.
          if (do_deq) begin
            head_q <= tail_q;
            if (do_enq) begin
              tail_q <= din;
            end else begin
              count <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: PC, BOOT/RUN/HALT FSM, redirect flush and prefetch queue.
// Optional performance counters are enabled by defining IFETCH_PERF_EN.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 65
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        halt_o
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS * 4);

  state_t           state_q;
  state_t           state_d;
  logic [31:0]      fetch_pc_q;
  logic [31:0]      fetch_pc_d;
  logic [1:0]       count;
  logic [IFQ_W-1:0] head;
  logic             in_range;
  logic             deq;
  logic             fetch_en;

  assign in_range      = fetch_pc_q < IMEM_LIMIT;
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = (count != 2'd0) && !redirect_i;
  assign deq           = instr_valid_o && instr_ready_i;
  assign fetch_en      = (state_q == ST_RUN) && in_range && !redirect_i &&
                         ((count < 2'(IFQ_DEPTH)) || deq);
  assign pc_o          = head[63:32];
  assign instr_o       = head[31:0];
  assign halt_o        = (state_q == ST_HALT) && (count == 2'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Redirect overrides everything; an out-of-range target falls into HALT a cycle later.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      state_d    = ST_RUN;
      fetch_pc_d = align_pc(redirect_pc_i);
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN:  if (!in_range) state_d = ST_HALT;
        default: state_d = state_q;
      endcase
      if (fetch_en) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end
  end

  ifetch_queue u_queue (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .enq   (fetch_en),
    .deq   (deq),
    .flush (redirect_i),
    .din   ({fetch_pc_q, imem_instr_i}),
    .dout  (head),
    .count (count)
  );

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_o <= 32'd0;
      stall_cnt_o <= 32'd0;
    end else begin
      if (fetch_en) begin
        fetch_cnt_o <= fetch_cnt_o + 32'd1;
      end
      if ((state_q == ST_RUN) && instr_valid_o && !instr_ready_i) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
